canny_gradient_pack: RTL and testbench

Producer of the packed 16-bit gradient word consumed by the non-maximum-suppression stage. Takes signed Sobel gradients gx/gy with vsync/href/clken, computes L1 magnitude, quantises direction to one of four one-hot NMS comparison axes, and classifies against frame-latched double thresholds. Emits `{class[1:0], dir[3:0], mag[9:0]}` plus a per-frame strong-pixel count. Sits between the Sobel stage and `canny_nonLocalMaxValue`.

---
 rtl/canny_pkg.sv | 32 +++
 rtl/canny_dir_quant.sv | 52 +++++
 rtl/canny_gradient_pack.sv | 183 ++++++++++++++++++
 tb/tb_canny_gradient_pack.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny gradient stages: packed-word field
// positions, one-hot NMS direction codes, class codes and tangent constants.
package canny_pkg;

    // Field positions inside the packed 16-bit gradient word {class, dir, mag}
    localparam int MAG_LSB = 0;
    localparam int DIR_LSB = 10;
    localparam int CLS_LSB = 14;

    // tan(22.5 deg) and tan(67.5 deg) in Q8
    localparam int TAN22_Q8 = 106;
    localparam int TAN67_Q8 = 618;

    // One-hot comparison axis used by non-maximum suppression.
    // DIR_D45 compares p13/p31 (gx, gy of opposite sign);
    // DIR_D135 compares p11/p33 (gx, gy of the same sign).
    typedef enum logic [3:0] {
        DIR_NONE = 4'b0000,
        DIR_H    = 4'b0001,
        DIR_D45  = 4'b0010,
        DIR_V    = 4'b0100,
        DIR_D135 = 4'b1000
    } dir_e;

    // Hysteresis class of a pixel
    typedef enum logic [1:0] {
        CLS_NONE   = 2'b00,
        CLS_WEAK   = 2'b01,
        CLS_STRONG = 2'b10
    } cls_e;

endpackage

// File: rtl/canny_dir_quant.sv
// Second pipeline stage of the gradient direction path: quantises the
// gradient angle to one of four NMS axes using Q8 tangent products.
module canny_dir_quant
    import canny_pkg::*;
#(
    parameter int GRAD_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_s,
    input  logic [GRAD_WIDTH-1:0] abs_x,
    input  logic [GRAD_WIDTH-1:0] abs_y,
    input  logic                  same_sign,
    output dir_e                  dir_q
);

    // Products are kept wide enough that no bit of |g| * 618 is lost
    localparam int PW = GRAD_WIDTH + 10;

    logic [PW-1:0] ay_scaled;
    logic [PW-1:0] ax_tan22;
    logic [PW-1:0] ax_tan67;
    dir_e          dir_d;

    // Compare ay against ax*tan22.5 and ax*tan67.5; equality falls to a diagonal
    always_comb begin
        ay_scaled = PW'(abs_y) << 8;
        ax_tan22  = PW'(abs_x) * PW'(TAN22_Q8);
        ax_tan67  = PW'(abs_x) * PW'(TAN67_Q8);
        dir_d     = DIR_NONE;
        if (abs_x == '0 && abs_y == '0) begin
            dir_d = DIR_NONE;
        end else if (ay_scaled < ax_tan22) begin
            dir_d = DIR_H;
        end else if (ay_scaled > ax_tan67) begin
            dir_d = DIR_V;
        end else if (same_sign) begin
            dir_d = DIR_D135;
        end else begin
            dir_d = DIR_D45;
        end
    end

    // Register the direction code alongside the magnitude of the same pixel
    always_ff @(posedge clk) begin
        if (rst_s) begin
            dir_q <= DIR_NONE;
        end else begin
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/canny_gradient_pack.sv
// Packs Sobel gradients into {class, dir, mag} words for NMS, with
// frame-latched double thresholds and a per-frame strong-pixel count.
module canny_gradient_pack
    import canny_pkg::*;
#(
    parameter int GRAD_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 20
) (
    input  logic                         clk,
    input  logic                         rst_s,
    input  logic                         per_frame_vsync,
    input  logic                         per_frame_href,
    input  logic                         per_frame_clken,
    input  logic signed [GRAD_WIDTH-1:0] grad_x,
    input  logic signed [GRAD_WIDTH-1:0] grad_y,
    input  logic [9:0]                   thr_high,
    input  logic [9:0]                   thr_low,
    output logic                         grandient_vs,
    output logic                         grandient_hs,
    output logic                         grandient_de,
    output logic [DATA_WIDTH-1:0]        gra_path,
    output logic [CNT_WIDTH-1:0]         frame_strong_cnt,
    output logic                         frame_done
);

    // Input-side frame edge detect and threshold latches
    logic vsync_prev_q, vsync_prev_d;
    logic [9:0] thr_high_l_q, thr_high_l_d;
    logic [9:0] thr_low_l_q, thr_low_l_d;
    // S1: absolute values, sign relation, strobes
    logic [GRAD_WIDTH-1:0] abs_x_q, abs_x_d;
    logic [GRAD_WIDTH-1:0] abs_y_q, abs_y_d;
    logic same_sign_q, same_sign_d;
    logic vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d;
    // S2: saturated magnitude (direction lives in the sub-module)
    logic [GRAD_WIDTH:0] mag_sum;
    logic [9:0] mag2_q, mag2_d;
    logic vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;
    dir_e dir2_q;
    // S3: class and packed word
    cls_e cls_d;
    logic [DATA_WIDTH-1:0] gra_path_q, gra_path_d;
    logic vs3_q, vs3_d, hs3_q, hs3_d, de3_q, de3_d;
    // Output-side strong-pixel accounting
    logic strong_out, out_fall;
    logic [CNT_WIDTH-1:0] acc_inc;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic done_q, done_d;
    logic gx_pos, gx_neg, gy_pos, gy_neg;

    // Next-state logic for every pipeline stage and the frame counter
    always_comb begin
        // Thresholds only move on the input vsync rising edge
        vsync_prev_d = per_frame_vsync;
        thr_high_l_d = thr_high_l_q;
        thr_low_l_d  = thr_low_l_q;
        if (per_frame_vsync && !vsync_prev_q) begin
            thr_high_l_d = thr_high;
            thr_low_l_d  = thr_low;
        end

        // S1: -(-2^(W-1)) wraps to 2^(W-1), which is correct read as unsigned
        gx_neg      = grad_x[GRAD_WIDTH-1];
        gy_neg      = grad_y[GRAD_WIDTH-1];
        gx_pos      = !gx_neg && (grad_x != '0);
        gy_pos      = !gy_neg && (grad_y != '0);
        abs_x_d     = gx_neg ? $unsigned(-grad_x) : $unsigned(grad_x);
        abs_y_d     = gy_neg ? $unsigned(-grad_y) : $unsigned(grad_y);
        same_sign_d = (gx_pos && gy_pos) || (gx_neg && gy_neg);
        vs1_d       = per_frame_vsync;
        hs1_d       = per_frame_href;
        de1_d       = per_frame_clken;

        // S2: L1 magnitude saturated to the 10-bit field
        mag_sum = {1'b0, abs_x_q} + {1'b0, abs_y_q};
        mag2_d  = (mag_sum > (GRAD_WIDTH + 1)'(1023)) ? 10'h3FF : mag_sum[9:0];
        vs2_d   = vs1_q;
        hs2_d   = hs1_q;
        de2_d   = de1_q;

        // S3: classify against this frame's thresholds and pack
        cls_d = CLS_NONE;
        if (mag2_q >= thr_high_l_q) begin
            cls_d = CLS_STRONG;
        end else if (mag2_q >= thr_low_l_q) begin
            cls_d = CLS_WEAK;
        end
        gra_path_d = '0;
        if (de2_q) begin
            gra_path_d[CLS_LSB +: 2] = cls_d;
            gra_path_d[DIR_LSB +: 4] = dir2_q;
            gra_path_d[MAG_LSB +: 10] = mag2_q;
        end
        vs3_d = vs2_q;
        hs3_d = hs2_q;
        de3_d = de2_q;

        // Count pixels as they leave; the frame closes when output vsync falls,
        // so the pixel on the output in that same cycle still belongs to it
        strong_out = de3_q && (gra_path_q[CLS_LSB +: 2] == CLS_STRONG);
        acc_inc    = acc_q;
        if (strong_out && (acc_q != '1)) begin
            acc_inc = acc_q + 1'b1;
        end
        out_fall = vs3_q && !vs2_q;
        acc_d    = acc_inc;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        if (out_fall) begin
            cnt_d  = acc_inc;
            acc_d  = '0;
            done_d = 1'b1;
        end
    end

    // State registers; reset drops in-flight pixels and reopens the thresholds
    always_ff @(posedge clk) begin
        if (rst_s) begin
            vsync_prev_q <= 1'b0;
            thr_high_l_q <= 10'h3FF;
            thr_low_l_q  <= 10'h3FF;
            abs_x_q      <= '0;
            abs_y_q      <= '0;
            same_sign_q  <= 1'b0;
            vs1_q        <= 1'b0;
            hs1_q        <= 1'b0;
            de1_q        <= 1'b0;
            mag2_q       <= '0;
            vs2_q        <= 1'b0;
            hs2_q        <= 1'b0;
            de2_q        <= 1'b0;
            gra_path_q   <= '0;
            vs3_q        <= 1'b0;
            hs3_q        <= 1'b0;
            de3_q        <= 1'b0;
            acc_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            thr_high_l_q <= thr_high_l_d;
            thr_low_l_q  <= thr_low_l_d;
            abs_x_q      <= abs_x_d;
            abs_y_q      <= abs_y_d;
            same_sign_q  <= same_sign_d;
            vs1_q        <= vs1_d;
            hs1_q        <= hs1_d;
            de1_q        <= de1_d;
            mag2_q       <= mag2_d;
            vs2_q        <= vs2_d;
            hs2_q        <= hs2_d;
            de2_q        <= de2_d;
            gra_path_q   <= gra_path_d;
            vs3_q        <= vs3_d;
            hs3_q        <= hs3_d;
            de3_q        <= de3_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    canny_dir_quant #(
        .GRAD_WIDTH (GRAD_WIDTH)
    ) u_dir_quant (
        .clk       (clk),
        .rst_s     (rst_s),
        .abs_x     (abs_x_q),
        .abs_y     (abs_y_q),
        .same_sign (same_sign_q),
        .dir_q     (dir2_q)
    );

    assign grandient_vs     = vs3_q;
    assign grandient_hs     = hs3_q;
    assign grandient_de     = de3_q;
    assign gra_path         = gra_path_q;
    assign frame_strong_cnt = cnt_q;
    assign frame_done       = done_q;

endmodule

// File: tb/tb_canny_gradient_pack.sv
// Directed bench for canny_gradient_pack: packing, direction boundaries,
// saturation, threshold latching, strong-pixel counting and reset.
module tb_canny_gradient_pack;

    localparam int GW = 11;
    localparam int DW = 16;
    localparam int CW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_s;
    logic                 vs, hs, de;
    logic signed [GW-1:0] gx, gy;
    logic [9:0]           thr_h, thr_l;
    logic                 gv, gh, gd;
    logic [DW-1:0]        gp;
    logic [CW-1:0]        fcnt;
    logic                 fdone;

    int checks   = 0;
    int failures = 0;

    canny_gradient_pack #(
        .GRAD_WIDTH (GW),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst_s            (rst_s),
        .per_frame_vsync  (vs),
        .per_frame_href   (hs),
        .per_frame_clken  (de),
        .grad_x           (gx),
        .grad_y           (gy),
        .thr_high         (thr_h),
        .thr_low          (thr_l),
        .grandient_vs     (gv),
        .grandient_hs     (gh),
        .grandient_de     (gd),
        .gra_path         (gp),
        .frame_strong_cnt (fcnt),
        .frame_done       (fdone)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int x, input int y, input logic v);
        gx = GW'(x);
        gy = GW'(y);
        de = v;
        hs = v;
    endtask

    // Reset clears all outputs; reset thresholds are 1023 until a vsync edge
    task automatic test_reset;
        rst_s = 1'b1;
        vs = 1'b0;
        thr_h = 10'd200;
        thr_l = 10'd80;
        set_px(0, 0, 1'b0);
        tick();
        tick();
        checks++;
        if ({gv, gh, gd, fdone, gp, fcnt} !== 40'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {gv, gh, gd, fdone, gp, fcnt});
        end
        rst_s = 1'b0;
        set_px(-1020, 1020, 1'b1);
        tick();
        set_px(0, 0, 1'b0);
        tick();
        tick();
        checks++;
        if ({gd, gp} !== {1'b1, 16'h8BFF}) begin
            failures++;
            $display("FAIL reset_thr_1023 got=%h exp=%h", {gd, gp}, {1'b1, 16'h8BFF});
        end
        $display("test_reset done");
    endtask

    // One pixel at a time inside a frame with thresholds 200/80
    task automatic test_single_pixels;
        int vx [14] = '{100, 0, 50, 50, 256, 256, 256, 256, -1020, 0, 200, 80, 79, -50};
        int vy [14] = '{0, -300, 50, -50, 106, 105, 618, 619, 1020, 0, 0, 0, 0, -50};
        logic [15:0] ev [14] = '{16'h4464, 16'h912C, 16'h6064, 16'h4864, 16'hA16A,
                                 16'h8569, 16'hA36A, 16'h936B, 16'h8BFF, 16'h0000,
                                 16'h84C8, 16'h4450, 16'h044F, 16'h6064};
        for (int i = 0; i < 14; i++) begin
            set_px(vx[i], vy[i], 1'b1);
            tick();
            set_px(0, 0, 1'b0);
            tick();
            checks++;
            if (gd !== 1'b0) begin
                failures++;
                $display("FAIL latency_early[%0d] got de=%b exp de=0", i, gd);
            end
            tick();
            checks++;
            if ({gv, gh, gd, gp} !== {3'b111, ev[i]}) begin
                failures++;
                $display("FAIL pixel[%0d] gx=%0d gy=%0d got=%h exp=%h",
                         i, vx[i], vy[i], {gv, gh, gd, gp}, {3'b111, ev[i]});
            end
            $display("pixel[%0d] gx=%0d gy=%0d word=%h", i, vx[i], vy[i], gp);
        end
    endtask

    // Consecutive pixels emerge on consecutive cycles; idle output word is zero
    task automatic test_back_to_back;
        int vx [3] = '{100, 0, 50};
        int vy [3] = '{0, -300, -50};
        logic [15:0] ev [3] = '{16'h4464, 16'h912C, 16'h4864};
        for (int i = 0; i < 3; i++) begin
            set_px(vx[i], vy[i], 1'b1);
            tick();
        end
        set_px(-1020, 1020, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({gd, gp} !== {1'b1, ev[i]}) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, {gd, gp}, {1'b1, ev[i]});
            end
            tick();
        end
        tick();
        checks++;
        if ({gd, gp} !== 17'h0) begin
            failures++;
            $display("FAIL idle_zero got=%h exp=0", {gd, gp});
        end
        $display("test_back_to_back done");
    endtask

    // Seven strong pixels; last one sits right before vsync falls
    task automatic test_count;
        vs = 1'b0;
        set_px(0, 0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        thr_h = 10'd200;
        thr_l = 10'd80;
        vs = 1'b1;
        set_px(0, -300, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 2) set_px(100, 0, 1'b1);
            else set_px(0, -300, 1'b1);
            tick();
        end
        set_px(0, 0, 1'b0);
        vs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (fdone !== (i == 2)) begin
                failures++;
                $display("FAIL done_timing[%0d] got=%b exp=%b", i, fdone, (i == 2));
            end
        end
        checks++;
        if (fcnt !== 20'd7) begin
            failures++;
            $display("FAIL strong_cnt got=%0d exp=7", fcnt);
        end
        $display("test_count cnt=%0d", fcnt);
    endtask

    // Mid-frame threshold change is ignored until the next frame,
    // which follows after a single-cycle vsync low
    task automatic test_thr_latch;
        int vx [3] = '{100, 100, 0};
        int vy [3] = '{0, 0, -300};
        logic [15:0] ev [3] = '{16'h4464, 16'h4464, 16'h912C};
        thr_h = 10'd200;
        vs = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_px(vx[i], vy[i], 1'b1);
            tick();
            set_px(0, 0, 1'b0);
            thr_h = 10'd50;
            tick();
            tick();
            checks++;
            if ({gd, gp} !== {1'b1, ev[i]}) begin
                failures++;
                $display("FAIL latch_frameA[%0d] got=%h exp=%h", i, {gd, gp}, {1'b1, ev[i]});
            end
        end
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        set_px(100, 0, 1'b1);
        tick();
        checks++;
        if ({gv, fdone, fcnt} !== {1'b0, 1'b1, 20'd1}) begin
            failures++;
            $display("FAIL frameA_close got=%h exp=%h", {gv, fdone, fcnt}, {1'b0, 1'b1, 20'd1});
        end
        set_px(0, 0, 1'b0);
        tick();
        checks++;
        if ({gv, fdone} !== 2'b10) begin
            failures++;
            $display("FAIL frameB_open got=%b exp=10", {gv, fdone});
        end
        tick();
        checks++;
        if ({gd, gp} !== {1'b1, 16'h8464}) begin
            failures++;
            $display("FAIL latch_frameB got=%h exp=%h", {gd, gp}, {1'b1, 16'h8464});
        end
        vs = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if ({fdone, fcnt} !== {1'b1, 20'd1}) begin
            failures++;
            $display("FAIL frameB_close got=%h exp=%h", {fdone, fcnt}, {1'b1, 20'd1});
        end
        $display("test_thr_latch done");
    endtask

    // Reset mid-frame zeroes outputs next cycle and never closes the frame
    task automatic test_midframe_reset;
        thr_h = 10'd200;
        vs = 1'b1;
        tick();
        set_px(0, -300, 1'b1);
        tick();
        tick();
        tick();
        checks++;
        if ({gv, gd, gp} !== {2'b11, 16'h912C}) begin
            failures++;
            $display("FAIL pre_reset got=%h exp=%h", {gv, gd, gp}, {2'b11, 16'h912C});
        end
        rst_s = 1'b1;
        tick();
        checks++;
        if ({gv, gh, gd, fdone, gp, fcnt} !== 40'h0) begin
            failures++;
            $display("FAIL midframe_reset got=%h exp=0", {gv, gh, gd, fdone, gp, fcnt});
        end
        rst_s = 1'b0;
        vs = 1'b0;
        set_px(0, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (fdone !== 1'b0) begin
                failures++;
                $display("FAIL aborted_done[%0d] got=%b exp=0", i, fdone);
            end
        end
        $display("test_midframe_reset done");
    endtask

    initial begin
        test_reset();
        thr_h = 10'd200;
        thr_l = 10'd80;
        vs = 1'b1;
        tick();
        test_single_pixels();
        test_back_to_back();
        test_count();
        test_thr_latch();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
